// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared widths, car class and default lot configuration
package parking_pkg;

  localparam int HOUR_W    = 5;
  localparam int DAY_HOURS = 24;

  typedef enum logic {
    CLASS_FREE = 1'b0,
    CLASS_RES  = 1'b1
  } car_class_t;

  localparam int DEF_TOTAL_CAPACITY = 700;
  localparam int DEF_CNT_W          = 10;
  localparam int DEF_CLOCKS_IN_HOUR = 500;
  localparam int DEF_HOUR_START     = 8;
  localparam int DEF_RES_CAP0       = 500;
  localparam int DEF_RES_CAP1       = 450;
  localparam int DEF_RES_CAP2       = 400;
  localparam int DEF_RES_CAP3       = 200;
  localparam int DEF_STEP1_H        = 6;
  localparam int DEF_STEP2_H        = 7;
  localparam int DEF_STEP3_H        = 8;

endpackage

// File: rtl/parking_timebase.sv
// rtl/parking_timebase.sv - tick/elapsed-hour counters and wall-clock hour
module parking_timebase
  import parking_pkg::*;
#(
  parameter int CLOCKS_IN_HOUR = DEF_CLOCKS_IN_HOUR,
  parameter int HOUR_START     = DEF_HOUR_START
) (
  input  logic              clock,
  input  logic              reset,
  output logic [HOUR_W-1:0] hour,
  output logic [HOUR_W-1:0] elapsed_next,
  output logic              hour_step,
  output logic              day_wrap
);

  localparam int TICK_W = (CLOCKS_IN_HOUR > 1) ? $clog2(CLOCKS_IN_HOUR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCKS_IN_HOUR - 1);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(DAY_HOURS - 1);

  logic [TICK_W-1:0] tick;
  logic [HOUR_W-1:0] elapsed;

  function automatic logic [HOUR_W-1:0] wall_hour(input logic [HOUR_W-1:0] e);
    return HOUR_W'((int'(e) + HOUR_START) % DAY_HOURS);
  endfunction

  // hour_step/day_wrap are high in the cycle whose closing edge advances the hour
  assign hour_step = (tick == TICK_LAST);
  assign day_wrap  = hour_step && (elapsed == LAST_HOUR);

  always_comb begin
    elapsed_next = elapsed;
    if (day_wrap)
      elapsed_next = '0;
    else if (hour_step)
      elapsed_next = elapsed + HOUR_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick    <= '0;
      elapsed <= '0;
      hour    <= HOUR_W'(HOUR_START % DAY_HOURS);
    end else begin
      tick    <= hour_step ? '0 : tick + TICK_W'(1);
      elapsed <= elapsed_next;
      hour    <= wall_hour(elapsed_next);
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// rtl/parking_lot_ctrl.sv - reserved/free pool occupancy with scheduled reserved capacity
// Optional PARKING_STATS_EN adds peak_total and reject_count outputs.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int TOTAL_CAPACITY = DEF_TOTAL_CAPACITY,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int CLOCKS_IN_HOUR = DEF_CLOCKS_IN_HOUR,
  parameter int HOUR_START     = DEF_HOUR_START,
  parameter int RES_CAP0       = DEF_RES_CAP0,
  parameter int RES_CAP1       = DEF_RES_CAP1,
  parameter int RES_CAP2       = DEF_RES_CAP2,
  parameter int RES_CAP3       = DEF_RES_CAP3,
  parameter int STEP1_H        = DEF_STEP1_H,
  parameter int STEP2_H        = DEF_STEP2_H,
  parameter int STEP3_H        = DEF_STEP3_H
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              entry_valid,
  input  logic              entry_is_res,
  input  logic              exit_valid,
  input  logic              exit_is_res,
  output logic [HOUR_W-1:0] hour,
  output logic [CNT_W-1:0]  res_parked,
  output logic [CNT_W-1:0]  free_parked,
  output logic [CNT_W-1:0]  res_vacant,
  output logic [CNT_W-1:0]  free_vacant,
  output logic              res_has_space,
  output logic              free_has_space,
  output logic              entry_accept,
  output logic              entry_reject,
  output logic              exit_fault,
  output logic              day_rollover
`ifdef PARKING_STATS_EN
  ,
  output logic [CNT_W-1:0]  peak_total,
  output logic [15:0]       reject_count
`endif
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_CAPACITY);

  logic [HOUR_W-1:0] elapsed_next;
  logic              hour_step;
  logic              day_wrap;
  logic [CNT_W-1:0]  res_cap;
  logic [CNT_W-1:0]  spill_cnt;
  logic [CNT_W-1:0]  cap_n, free_cap_n, excess;
  logic [CNT_W-1:0]  r_n, f_n, s_n;
  logic              acc_n, rej_n, flt_n;
  car_class_t        entry_class, exit_class;

  parking_timebase #(
    .CLOCKS_IN_HOUR(CLOCKS_IN_HOUR),
    .HOUR_START    (HOUR_START)
  ) u_timebase (
    .clock       (clock),
    .reset       (reset),
    .hour        (hour),
    .elapsed_next(elapsed_next),
    .hour_step   (hour_step),
    .day_wrap    (day_wrap)
  );

  function automatic logic [CNT_W-1:0] cap_of(input logic [HOUR_W-1:0] e);
    if (int'(e) >= STEP3_H)      return CNT_W'(RES_CAP3);
    else if (int'(e) >= STEP2_H) return CNT_W'(RES_CAP2);
    else if (int'(e) >= STEP1_H) return CNT_W'(RES_CAP1);
    else                         return CNT_W'(RES_CAP0);
  endfunction

  assign entry_class = car_class_t'(entry_is_res);
  assign exit_class  = car_class_t'(exit_is_res);

  // Spill, then exit, then entry, so a same-cycle exit frees a space for the entry
  always_comb begin
    cap_n      = hour_step ? cap_of(elapsed_next) : res_cap;
    free_cap_n = TOTAL - cap_n;
    r_n        = res_parked;
    f_n        = free_parked;
    s_n        = spill_cnt;
    excess     = '0;
    acc_n      = 1'b0;
    rej_n      = 1'b0;
    flt_n      = 1'b0;
    if (day_wrap) begin
      r_n = '0;
      f_n = '0;
      s_n = '0;
    end else begin
      if (r_n > cap_n) begin
        excess = r_n - cap_n;
        r_n    = cap_n;
        f_n    = f_n + excess;
        s_n    = s_n + excess;
      end
      if (exit_valid) begin
        if (exit_class == CLASS_RES) begin
          if (r_n != '0) begin
            r_n = r_n - ONE;
          end else if (s_n != '0) begin
            f_n = f_n - ONE;
            s_n = s_n - ONE;
          end else begin
            flt_n = 1'b1;
          end
        end else if (f_n > s_n) begin
          f_n = f_n - ONE;
        end else begin
          flt_n = 1'b1;
        end
      end
      if (entry_valid) begin
        if (entry_class == CLASS_RES) begin
          if (r_n < cap_n) begin
            r_n   = r_n + ONE;
            acc_n = 1'b1;
          end else begin
            rej_n = 1'b1;
          end
        end else if (f_n < free_cap_n) begin
          f_n   = f_n + ONE;
          acc_n = 1'b1;
        end else begin
          rej_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_cap        <= CNT_W'(RES_CAP0);
      res_parked     <= '0;
      free_parked    <= '0;
      spill_cnt      <= '0;
      res_vacant     <= CNT_W'(RES_CAP0);
      free_vacant    <= TOTAL - CNT_W'(RES_CAP0);
      res_has_space  <= 1'b1;
      free_has_space <= 1'b1;
      entry_accept   <= 1'b0;
      entry_reject   <= 1'b0;
      exit_fault     <= 1'b0;
      day_rollover   <= 1'b0;
    end else begin
      res_cap        <= cap_n;
      res_parked     <= r_n;
      free_parked    <= f_n;
      spill_cnt      <= s_n;
      res_vacant     <= cap_n - r_n;
      free_vacant    <= free_cap_n - f_n;
      res_has_space  <= (cap_n != r_n);
      free_has_space <= (free_cap_n != f_n);
      entry_accept   <= acc_n;
      entry_reject   <= rej_n;
      exit_fault     <= flt_n;
      day_rollover   <= day_wrap;
    end
  end

`ifdef PARKING_STATS_EN
  logic [CNT_W-1:0] total_n;
  assign total_n = r_n + f_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_total   <= '0;
      reject_count <= '0;
    end else if (day_wrap) begin
      peak_total   <= '0;
      reject_count <= '0;
    end else begin
      if (total_n > peak_total)
        peak_total <= total_n;
      if (rej_n && (reject_count != 16'hFFFF))
        reject_count <= reject_count + 16'd1;
    end
  end
`endif

  always @(posedge clock) begin
    if (reset) begin
      assert (spill_cnt <= free_parked);
      assert (res_parked <= res_cap);
      assert (({1'b0, res_parked} + {1'b0, free_parked}) <= (CNT_W+1)'(TOTAL_CAPACITY));
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb/tb_parking_lot_ctrl.sv - directed self-checking bench for parking_lot_ctrl
module tb_parking_lot_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       entry_valid, entry_is_res, exit_valid, exit_is_res;
  logic [4:0] hour;
  logic [9:0] res_parked, free_parked, res_vacant, free_vacant;
  logic       res_has_space, free_has_space;
  logic       entry_accept, entry_reject, exit_fault, day_rollover;
`ifdef PARKING_STATS_EN
  logic [9:0]  peak_total;
  logic [15:0] reject_count;
`endif

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int n_acc = 0;

  always #5 clock = ~clock;

  parking_lot_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .entry_valid   (entry_valid),
    .entry_is_res  (entry_is_res),
    .exit_valid    (exit_valid),
    .exit_is_res   (exit_is_res),
    .hour          (hour),
    .res_parked    (res_parked),
    .free_parked   (free_parked),
    .res_vacant    (res_vacant),
    .free_vacant   (free_vacant),
    .res_has_space (res_has_space),
    .free_has_space(free_has_space),
    .entry_accept  (entry_accept),
    .entry_reject  (entry_reject),
    .exit_fault    (exit_fault),
    .day_rollover  (day_rollover)
`ifdef PARKING_STATS_EN
    ,
    .peak_total    (peak_total),
    .reject_count  (reject_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ncyc++;
    entry_valid = 1'b0;
    exit_valid  = 1'b0;
  endtask

  task automatic ev(input logic en, input logic eres, input logic xv, input logic xres);
    entry_valid  = en;
    entry_is_res = eres;
    exit_valid   = xv;
    exit_is_res  = xres;
    step();
  endtask

  initial begin
    reset = 1'b0;
    entry_valid = 1'b0; entry_is_res = 1'b0;
    exit_valid  = 1'b0; exit_is_res  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hour", hour, 8);
    chk("rst_res_vacant", res_vacant, 500);
    chk("rst_free_vacant", free_vacant, 200);
    chk("rst_res_parked", res_parked, 0);
    chk("rst_flags", {res_has_space, free_has_space, entry_accept, entry_reject, exit_fault, day_rollover}, 6'b110000);
    reset = 1'b1;
    ncyc = 0;

    step();
    chk("idle_hour", hour, 8);
    chk("idle_pulses", {entry_accept, entry_reject, exit_fault, day_rollover}, 0);
    chk("idle_free_vacant", free_vacant, 200);

    ev(0, 0, 1, 0);
    chk("free_exit_fault", exit_fault, 1);
    chk("free_exit_fault_cnt", free_parked, 0);
    ev(0, 0, 1, 1);
    chk("res_exit_fault", exit_fault, 1);

    n_acc = 0;
    for (int i = 0; i < 200; i++) begin
      ev(1, 0, 0, 0);
      if (entry_accept) n_acc++;
    end
    chk("free_fill_accepts", n_acc, 200);
    chk("free_fill_parked", free_parked, 200);
    chk("free_full_vacant", free_vacant, 0);
    chk("free_full_space", free_has_space, 0);
    chk("free_full_res_space", res_has_space, 1);
    ev(1, 0, 0, 0);
    chk("free_over_reject", {entry_accept, entry_reject}, 2'b01);
    chk("free_over_parked", free_parked, 200);

    for (int i = 0; i < 500; i++) ev(1, 1, 0, 0);
    chk("res_fill_parked", res_parked, 500);
    chk("res_full_vacant", res_vacant, 0);
    chk("res_full_space", res_has_space, 0);
    ev(1, 1, 1, 1);
    chk("simul_pulses", {entry_accept, entry_reject, exit_fault}, 3'b100);
    chk("simul_parked", res_parked, 500);
    ev(1, 1, 0, 0);
    chk("res_over_reject", entry_reject, 1);

    for (int i = 0; i < 20; i++) ev(0, 0, 1, 1);
    chk("res_drain20", res_parked, 480);

    while (ncyc < 2999) step();
    chk("pre_step_hour", hour, 13);
    chk("pre_step_res", res_parked, 480);
    step();
    chk("spill_hour", hour, 14);
    chk("spill_res", res_parked, 450);
    chk("spill_free", free_parked, 230);
    chk("spill_res_vacant", res_vacant, 0);
    chk("spill_free_vacant", free_vacant, 20);

    for (int i = 0; i < 450; i++) ev(0, 0, 1, 1);
    chk("drain_res", res_parked, 0);
    chk("drain_res_vacant", res_vacant, 450);
    chk("drain_free", free_parked, 230);
    ev(0, 0, 1, 1);
    chk("spill_exit_nofault", exit_fault, 0);
    chk("spill_exit_free", free_parked, 229);
    for (int i = 0; i < 200; i++) ev(0, 0, 1, 0);
    chk("free_drain", free_parked, 29);
    ev(0, 0, 1, 0);
    chk("free_exit_only_spill", exit_fault, 1);
    chk("free_exit_only_spill_cnt", free_parked, 29);
    ev(0, 0, 1, 1);
    chk("spill_exit2", {exit_fault, free_parked}, {1'b0, 10'd28});
    chk("cap2_free_vacant", free_vacant, 272);

    for (int i = 0; i < 5; i++) ev(1, 1, 0, 0);
    while (ncyc < 11999) step();
    chk("pre_roll_hour", hour, 7);
    chk("pre_roll_res", res_parked, 5);
    chk("pre_roll_free", free_parked, 28);
    chk("pre_roll_res_vacant", res_vacant, 195);
    chk("pre_roll_free_vacant", free_vacant, 472);
    chk("pre_roll_pulse", day_rollover, 0);
`ifdef PARKING_STATS_EN
    chk("stats_peak", peak_total, 700);
    chk("stats_rejects", reject_count, 2);
`endif
    ev(1, 0, 0, 0);
    chk("roll_pulse", day_rollover, 1);
    chk("roll_entry_dropped", {entry_accept, entry_reject}, 0);
    chk("roll_counts", {res_parked, free_parked}, 0);
    chk("roll_res_vacant", res_vacant, 500);
    chk("roll_free_vacant", free_vacant, 200);
    chk("roll_hour", hour, 8);
`ifdef PARKING_STATS_EN
    chk("roll_stats", {peak_total, reject_count}, 0);
`endif
    step();
    chk("roll_pulse_end", day_rollover, 0);

    ev(1, 0, 0, 0);
    chk("pre_reset_free", free_parked, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_free", free_parked, 0);
    chk("async_reset_vacant", free_vacant, 200);
    @(posedge clock);
    #1;
    reset = 1'b1;
    ev(1, 0, 0, 0);
    chk("post_reset_entry", {entry_accept, free_parked}, {1'b1, 10'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
